// File: rtl/isqrt_result_fifo_if.sv
// Result stream bundle between isqrt pipeline, output FIFO and consumer.
// slave = FIFO side; master = pipeline/consumer (testbench) side.
interface isqrt_result_fifo_if;
    logic [31:0] in_data;
    logic        in_valid;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;

    modport slave (
        input  in_data,
        input  in_valid,
        input  out_ready,
        output out_data,
        output out_valid
    );

    modport master (
        output in_data,
        output in_valid,
        output out_ready,
        input  out_data,
        input  out_valid
    );
endinterface

// File: rtl/isqrt_result_fifo.sv
// FWFT result FIFO behind the fast inverse-sqrt pipeline, with drop tracking.
// Optional macro ISQRT_FIFO_NAN_FILTER_EN: discard Inf/NaN/negative results and count them.
module isqrt_result_fifo #(
    parameter int DEPTH       = 16,
    parameter int AFULL_LEVEL = 12,
    parameter int CNT_W       = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    isqrt_result_fifo_if.slave         bus,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       almost_full,
    output logic                       overflow,
    output logic [CNT_W-1:0]           drop_cnt,
`ifdef ISQRT_FIFO_NAN_FILTER_EN
    output logic [CNT_W-1:0]           bad_cnt,
`endif
    input  logic                       overflow_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]      mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             valid_q, valid_d;
    logic             afull_q, afull_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] drop_q, drop_d;

    logic             bad_in;
    logic             take_in;
    logic             full;
    logic             pop;
    logic             push;
    logic             drop;

`ifdef ISQRT_FIFO_NAN_FILTER_EN
    logic [CNT_W-1:0] bad_q, bad_d;
    assign bad_in = bus.in_data[31] || (bus.in_data[30:23] == 8'hFF);
`else
    assign bad_in = 1'b0;
`endif

    assign take_in = bus.in_valid && !bad_in;
    assign full    = (count_q == CW'(DEPTH));
    assign pop     = valid_q && bus.out_ready;
    assign push    = take_in && (!full || pop);
    assign drop    = take_in && full && !pop;

    // Next-state for pointers, occupancy and status flags
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        drop_d   = drop_q;

        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

        if (push && !pop)      count_d = count_q + CW'(1);
        else if (pop && !push) count_d = count_q - CW'(1);

        if (overflow_clr) begin
            ovf_d  = 1'b0;
            drop_d = '0;
        end
        if (drop) begin
            ovf_d = 1'b1;
            if (drop_d != {CNT_W{1'b1}}) drop_d = drop_d + CNT_W'(1);
        end

        valid_d = (count_d != '0);
        afull_d = (count_d >= CW'(AFULL_LEVEL));
    end

`ifdef ISQRT_FIFO_NAN_FILTER_EN
    // Saturating count of filtered Inf/NaN/negative results
    always_comb begin
        bad_d = bad_q;
        if (overflow_clr) bad_d = '0;
        if (bus.in_valid && bad_in && bad_d != {CNT_W{1'b1}})
            bad_d = bad_d + CNT_W'(1);
    end

    // Filter counter register
    always_ff @(posedge clk) begin
        if (rst) bad_q <= '0;
        else     bad_q <= bad_d;
    end

    assign bad_cnt = bad_q;
`endif

    // Control and status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            afull_q  <= 1'b0;
            ovf_q    <= 1'b0;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            afull_q  <= afull_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
        end
    end

    // Storage array, deliberately not reset
    always_ff @(posedge clk) begin
        if (!rst && push) mem_q[wr_ptr_q] <= bus.in_data;
    end

    assign bus.out_data  = mem_q[rd_ptr_q];
    assign bus.out_valid = valid_q;
    assign count         = count_q;
    assign almost_full   = afull_q;
    assign overflow      = ovf_q;
    assign drop_cnt      = drop_q;

endmodule

// File: tb/tb_isqrt_result_fifo.sv
// Directed self-checking bench for isqrt_result_fifo.
// Build with ISQRT_FIFO_NAN_FILTER_EN to also exercise the input filter.
module tb_isqrt_result_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       overflow_clr;
    logic [4:0] count;
    logic       almost_full;
    logic       overflow;
    logic [7:0] drop_cnt;
`ifdef ISQRT_FIFO_NAN_FILTER_EN
    logic [7:0] bad_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    isqrt_result_fifo_if bus();

    isqrt_result_fifo #(
        .DEPTH(16),
        .AFULL_LEVEL(12),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .count(count),
        .almost_full(almost_full),
        .overflow(overflow),
        .drop_cnt(drop_cnt),
`ifdef ISQRT_FIFO_NAN_FILTER_EN
        .bad_cnt(bad_cnt),
`endif
        .overflow_clr(overflow_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] v);
        bus.in_data  = v;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    logic [31:0] t1 [3];

    initial begin
        rst          = 1'b1;
        overflow_clr = 1'b0;
        bus.in_data  = '0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        check("rst_count", 32'(count), 0);
        check("rst_valid", 32'(bus.out_valid), 0);
        check("rst_afull", 32'(almost_full), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_drop", 32'(drop_cnt), 0);

        // Test 1: three pushes, then drain in order
        t1[0] = 32'h3F800000;
        t1[1] = 32'h3F3504F3;
        t1[2] = 32'h3F000000;
        push(t1[0]);
        check("t1_valid1", 32'(bus.out_valid), 1);
        check("t1_head1", bus.out_data, t1[0]);
        check("t1_count1", 32'(count), 1);
        push(t1[1]);
        push(t1[2]);
        check("t1_count3", 32'(count), 3);
        check("t1_head3", bus.out_data, t1[0]);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("t1_pop_valid", 32'(bus.out_valid), 1);
            check("t1_pop_data", bus.out_data, t1[i]);
            tick();
        end
        bus.out_ready = 1'b0;
        check("t1_empty_valid", 32'(bus.out_valid), 0);
        check("t1_empty_count", 32'(count), 0);

        // Test 2: fill to 16, almost_full at 12, 17th dropped
        for (int i = 0; i < 16; i++) begin
            push(32'h1000 + 32'(i));
            if (i == 10) check("t2_afull_11", 32'(almost_full), 0);
            if (i == 11) begin
                check("t2_afull_12", 32'(almost_full), 1);
                check("t2_count_12", 32'(count), 12);
            end
        end
        check("t2_count_full", 32'(count), 16);
        push(32'hDEADBEEF);
        check("t2_ovf", 32'(overflow), 1);
        check("t2_drop", 32'(drop_cnt), 1);
        check("t2_count", 32'(count), 16);
        check("t2_head", bus.out_data, 32'h1000);

        // Test 3: full with simultaneous push and pop
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            bus.in_data = 32'h2000 + 32'(k);
            check("t3_pop_data", bus.out_data, 32'h1000 + 32'(k));
            tick();
            check("t3_count", 32'(count), 16);
        end
        bus.out_ready = 1'b0;
        check("t3_drop", 32'(drop_cnt), 1);

        // Test 4: saturating drop counter and clear
        bus.in_data = 32'h3F400000;
        for (int k = 0; k < 300; k++) tick();
        check("t4_sat", 32'(drop_cnt), 255);
        check("t4_ovf", 32'(overflow), 1);
        overflow_clr = 1'b1;
        tick();
        check("t4_clr_drop_ovf", 32'(overflow), 1);
        check("t4_clr_drop_cnt", 32'(drop_cnt), 1);
        bus.in_valid = 1'b0;
        tick();
        overflow_clr = 1'b0;
        check("t4_clr_ovf", 32'(overflow), 0);
        check("t4_clr_cnt", 32'(drop_cnt), 0);
        check("t4_count", 32'(count), 16);
        check("t4_head", bus.out_data, 32'h1005);

        // Test 5: reset mid-stream
        do_reset();
        check("t5_pre_count", 32'(count), 0);
        for (int i = 0; i < 6; i++) push(32'h3000 + 32'(i));
        check("t5_count6", 32'(count), 6);
        bus.out_ready = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.out_ready = 1'b0;
        check("t5_count", 32'(count), 0);
        check("t5_valid", 32'(bus.out_valid), 0);
        check("t5_afull", 32'(almost_full), 0);
        push(32'h40000000);
        check("t5_push_valid", 32'(bus.out_valid), 1);
        check("t5_push_data", bus.out_data, 32'h40000000);
        check("t5_push_count", 32'(count), 1);

`ifdef ISQRT_FIFO_NAN_FILTER_EN
        // Test 6: NaN and negative results filtered
        do_reset();
        push(32'h7FC00000);
        push(32'hBF800000);
        push(32'h3E800000);
        check("t6_count", 32'(count), 1);
        check("t6_bad", 32'(bad_cnt), 2);
        check("t6_ovf", 32'(overflow), 0);
        check("t6_head", bus.out_data, 32'h3E800000);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
